// File: rtl/mem_arbiter_pkg.sv
// Shared types for the CPU/debug RAM arbiter: FSM states and grant owner encoding.
package MemArbPkg;

   typedef enum logic {ArbIdle, ArbDbgBurst} arb_state_e;

   typedef enum logic [1:0] {OwnNone, OwnCpu, OwnDbg} arb_owner_e;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates the unified RAM between the CPU and the debug/loader port.
// CPU wins by default; debug gets locked bursts and a starvation-forced grant.
module mem_arbiter
   import MemArbPkg::*;
#(
   parameter int unsigned MAX_BURST    = 8,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_wdata,
   output logic        cpu_gnt,
   output logic        cpu_rvalid,
   output logic [31:0] cpu_rdata,
   input  logic        dbg_req,
   input  logic        dbg_we,
   input  logic [31:0] dbg_addr,
   input  logic [31:0] dbg_wdata,
   input  logic        dbg_last,
   output logic        dbg_gnt,
   output logic        dbg_rvalid,
   output logic [31:0] dbg_rdata,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        mem_we,
   input  logic [31:0] mem_rdata
);

   localparam int BW = $clog2(MAX_BURST + 1);
   localparam int SW = $clog2(STARVE_LIMIT + 1);

   arb_state_e  state_q, state_d;
   logic [BW-1:0] burst_cnt_q, burst_cnt_d;
   logic [SW-1:0] starve_cnt_q, starve_cnt_d;
   arb_owner_e  owner;
   arb_owner_e  rd_owner_q, rd_owner_d;
   logic [31:0] cpu_rdata_q, dbg_rdata_q;

   // Grant decision; forced to nobody while reset is held so no RAM write slips through.
   always_comb begin
      owner = OwnNone;
      if (!reset) begin
         case (state_q)
            ArbIdle: begin
               if (dbg_req && starve_cnt_q == SW'(STARVE_LIMIT)) owner = OwnDbg;
               else if (cpu_req)                                 owner = OwnCpu;
               else if (dbg_req)                                 owner = OwnDbg;
            end
            ArbDbgBurst: begin
               if (dbg_req)      owner = OwnDbg;
               else if (cpu_req) owner = OwnCpu;
            end
            default: owner = OwnNone;
         endcase
      end
   end

   assign cpu_gnt = (owner == OwnCpu);
   assign dbg_gnt = (owner == OwnDbg);

   always_comb begin
      mem_addr  = '0;
      mem_wdata = '0;
      mem_we    = 1'b0;
      case (owner)
         OwnCpu: begin
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
            mem_we    = cpu_we;
         end
         OwnDbg: begin
            mem_addr  = dbg_addr;
            mem_wdata = dbg_wdata;
            mem_we    = dbg_we;
         end
         default: ;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      burst_cnt_d = burst_cnt_q;
      case (state_q)
         ArbIdle: begin
            if (dbg_gnt && !dbg_last && MAX_BURST > 1) begin
               state_d     = ArbDbgBurst;
               burst_cnt_d = BW'(1);
            end
         end
         ArbDbgBurst: begin
            // Lock ends on last beat, on the beat cap, or when the debug side lets go.
            if (!dbg_req || dbg_last || burst_cnt_q == BW'(MAX_BURST - 1)) begin
               state_d     = ArbIdle;
               burst_cnt_d = '0;
            end else begin
               burst_cnt_d = burst_cnt_q + 1'b1;
            end
         end
         default: begin
            state_d     = ArbIdle;
            burst_cnt_d = '0;
         end
      endcase
   end

   always_comb begin
      starve_cnt_d = starve_cnt_q;
      if (!dbg_req || dbg_gnt)
         starve_cnt_d = '0;
      else if (cpu_gnt && starve_cnt_q != SW'(STARVE_LIMIT))
         starve_cnt_d = starve_cnt_q + 1'b1;
   end

   assign rd_owner_d = (owner != OwnNone && !mem_we) ? owner : OwnNone;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ArbIdle;
         burst_cnt_q  <= '0;
         starve_cnt_q <= '0;
         rd_owner_q   <= OwnNone;
         cpu_rdata_q  <= '0;
         dbg_rdata_q  <= '0;
      end else begin
         state_q      <= state_d;
         burst_cnt_q  <= burst_cnt_d;
         starve_cnt_q <= starve_cnt_d;
         rd_owner_q   <= rd_owner_d;
         if (rd_owner_d == OwnCpu) cpu_rdata_q <= mem_rdata;
         if (rd_owner_d == OwnDbg) dbg_rdata_q <= mem_rdata;
      end
   end

   assign cpu_rvalid = (rd_owner_q == OwnCpu);
   assign dbg_rvalid = (rd_owner_q == OwnDbg);
   assign cpu_rdata  = cpu_rdata_q;
   assign dbg_rdata  = dbg_rdata_q;

endmodule
